// File: rtl/heartbeat_scheduler.sv
// rtl/heartbeat_scheduler.sv - periodic round scheduler for a bank of heartbeat request units
//
// Purpose:
//   On every period tick, runs one round over the channels enabled in ch_mask
//   (sampled at round start), lowest index first. Each channel gets a
//   single-cycle start pulse. The scheduler then waits for that channel's done
//   (or a timeout) and emits one event per channel.
//
// Ports:
//   clk, rst_n    system clock (posedge), asynchronous active-low reset
//   enable        runs the period counter and rounds
//   period        cycles between ticks, 0 disables ticks
//   ch_mask       per-channel enables
//   hb_start      one-hot single-cycle start pulse to unit i
//   hb_done       done level from unit i
//   hb_result     per-unit 32-bit results, packed {ch[N-1]..ch[0]}
//   evt_valid     one-cycle event pulse; evt_ch / evt_result / evt_timeout
//   overrun       sticky: a tick arrived during a round
//   timeout_cnt   saturating count of timeouts
//   busy          round in progress

module heartbeat_scheduler #(
   parameter int NUM_CH   = 4,
   parameter int TIMEOUT  = 16,
   parameter int PERIOD_W = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   enable,
   input  logic [PERIOD_W-1:0]    period,
   input  logic [NUM_CH-1:0]      ch_mask,
   output logic [NUM_CH-1:0]      hb_start,
   input  logic [NUM_CH-1:0]      hb_done,
   input  logic [NUM_CH*32-1:0]   hb_result,
   output logic                   evt_valid,
   output logic [3:0]             evt_ch,
   output logic [31:0]            evt_result,
   output logic                   evt_timeout,
   output logic                   overrun,
   output logic [15:0]            timeout_cnt,
   output logic                   busy
);

   localparam int WCNT_W = $clog2(TIMEOUT);
   // The wait counter reads 0 in the first WAIT_DONE cycle, so the cycle that
   // lands REPORT exactly TIMEOUT cycles after ISSUE is count TIMEOUT-2.
   localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(TIMEOUT - 2);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_TICK,
      S_ISSUE,
      S_WAIT_DONE,
      S_REPORT
   } state_t;

   function automatic logic [3:0] lowest(input logic [NUM_CH-1:0] m);
      lowest = 4'd0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (m[i]) lowest = i[3:0];
      end
   endfunction

   function automatic logic [NUM_CH-1:0] onehot(input logic [3:0] s);
      onehot = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (s == i[3:0]) onehot[i] = 1'b1;
      end
   endfunction

   state_t               state_q, state_d;
   logic [PERIOD_W-1:0]  pcnt_q, pcnt_d;
   logic [NUM_CH-1:0]    mask_q, mask_d;
   logic [3:0]           sel_q, sel_d;
   logic [WCNT_W-1:0]    wcnt_q, wcnt_d;
   logic [NUM_CH-1:0]    hb_start_q, hb_start_d;
   logic                 evt_valid_q, evt_valid_d;
   logic [3:0]           evt_ch_q, evt_ch_d;
   logic [31:0]          evt_result_q, evt_result_d;
   logic                 evt_timeout_q, evt_timeout_d;
   logic                 overrun_q, overrun_d;
   logic [15:0]          timeout_cnt_q, timeout_cnt_d;
   logic                 busy_q, busy_d;

   logic                 tick;
   logic                 done_sel;
   logic [31:0]          result_sel;
   logic [3:0]           first_sel;
   logic [NUM_CH-1:0]    rem_mask;
   logic [3:0]           next_sel;

   assign tick      = enable && (period != '0) && (pcnt_q == '0);
   assign first_sel = lowest(ch_mask);
   assign rem_mask  = mask_q & ~onehot(sel_q);
   assign next_sel  = lowest(rem_mask);

   // Only the selected channel's done/result are ever looked at.
   always_comb begin
      done_sel   = 1'b0;
      result_sel = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (sel_q == i[3:0]) begin
            done_sel   = hb_done[i];
            result_sel = hb_result[i*32 +: 32];
         end
      end
   end

   always_comb begin
      if (!enable || (period == '0)) begin
         pcnt_d = '0;
      end else if (pcnt_q == '0) begin
         pcnt_d = period - 1'b1;
      end else begin
         pcnt_d = pcnt_q - 1'b1;
      end
   end

   always_comb begin
      state_d       = state_q;
      mask_d        = mask_q;
      sel_d         = sel_q;
      wcnt_d        = wcnt_q;
      hb_start_d    = '0;
      evt_valid_d   = 1'b0;
      evt_ch_d      = evt_ch_q;
      evt_result_d  = evt_result_q;
      evt_timeout_d = evt_timeout_q;
      timeout_cnt_d = timeout_cnt_q;
      busy_d        = busy_q;
      // A tick that lands while a round is running is dropped and flagged.
      overrun_d     = overrun_q | (tick & busy_q);

      case (state_q)
         S_IDLE: begin
            if (enable) state_d = S_WAIT_TICK;
         end
         S_WAIT_TICK: begin
            if (!enable) begin
               state_d = S_IDLE;
            end else if (tick && (ch_mask != '0)) begin
               mask_d     = ch_mask;
               sel_d      = first_sel;
               hb_start_d = onehot(first_sel);
               busy_d     = 1'b1;
               state_d    = S_ISSUE;
            end
         end
         S_ISSUE: begin
            wcnt_d  = '0;
            state_d = S_WAIT_DONE;
         end
         S_WAIT_DONE: begin
            wcnt_d = wcnt_q + 1'b1;
            // First cycle skipped: done may still be high from the last job.
            if ((wcnt_q != '0) && done_sel) begin
               evt_valid_d   = 1'b1;
               evt_ch_d      = sel_q;
               evt_result_d  = result_sel;
               evt_timeout_d = 1'b0;
               state_d       = S_REPORT;
            end else if (wcnt_q == WCNT_LAST) begin
               evt_valid_d   = 1'b1;
               evt_ch_d      = sel_q;
               evt_result_d  = '0;
               evt_timeout_d = 1'b1;
               if (timeout_cnt_q != 16'hFFFF) timeout_cnt_d = timeout_cnt_q + 16'd1;
               state_d       = S_REPORT;
            end
         end
         S_REPORT: begin
            mask_d = rem_mask;
            if ((rem_mask != '0) && enable) begin
               sel_d      = next_sel;
               hb_start_d = onehot(next_sel);
               state_d    = S_ISSUE;
            end else begin
               busy_d  = 1'b0;
               state_d = enable ? S_WAIT_TICK : S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         pcnt_q        <= '0;
         mask_q        <= '0;
         sel_q         <= '0;
         wcnt_q        <= '0;
         hb_start_q    <= '0;
         evt_valid_q   <= 1'b0;
         evt_ch_q      <= '0;
         evt_result_q  <= '0;
         evt_timeout_q <= 1'b0;
         overrun_q     <= 1'b0;
         timeout_cnt_q <= '0;
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         pcnt_q        <= pcnt_d;
         mask_q        <= mask_d;
         sel_q         <= sel_d;
         wcnt_q        <= wcnt_d;
         hb_start_q    <= hb_start_d;
         evt_valid_q   <= evt_valid_d;
         evt_ch_q      <= evt_ch_d;
         evt_result_q  <= evt_result_d;
         evt_timeout_q <= evt_timeout_d;
         overrun_q     <= overrun_d;
         timeout_cnt_q <= timeout_cnt_d;
         busy_q        <= busy_d;
      end
   end

   assign hb_start    = hb_start_q;
   assign evt_valid   = evt_valid_q;
   assign evt_ch      = evt_ch_q;
   assign evt_result  = evt_result_q;
   assign evt_timeout = evt_timeout_q;
   assign overrun     = overrun_q;
   assign timeout_cnt = timeout_cnt_q;
   assign busy        = busy_q;

endmodule

// File: tb/tb_heartbeat_scheduler.sv
// tb/tb_heartbeat_scheduler.sv - directed self-checking bench for heartbeat_scheduler

module tb_heartbeat_scheduler;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          enable = 1'b0;
   logic [15:0]   period = 16'd0;
   logic [3:0]    ch_mask = 4'd0;
   logic [3:0]    hb_start;
   logic [3:0]    hb_done;
   logic [127:0]  hb_result;
   logic          evt_valid;
   logic [3:0]    evt_ch;
   logic [31:0]   evt_result;
   logic          evt_timeout;
   logic          overrun;
   logic [15:0]   timeout_cnt;
   logic          busy;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   heartbeat_scheduler #(.NUM_CH(4), .TIMEOUT(16), .PERIOD_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .period(period), .ch_mask(ch_mask),
      .hb_start(hb_start), .hb_done(hb_done), .hb_result(hb_result),
      .evt_valid(evt_valid), .evt_ch(evt_ch), .evt_result(evt_result),
      .evt_timeout(evt_timeout), .overrun(overrun), .timeout_cnt(timeout_cnt), .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Unit models: done rises lat cycles after start (lat 0 = never) and stays
   // high until the next start. A sticky unit keeps the old done one extra cycle.
   int          lat[4];
   bit          sticky[4];
   logic [31:0] res_val[4];
   logic [31:0] init_res[4];
   logic [3:0]  init_done;
   int          age[4];
   logic [3:0]  done_lvl;
   logic [31:0] res_out[4];

   always @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (!rst_n) begin
            done_lvl[i] <= init_done[i];
            res_out[i]  <= init_res[i];
            age[i]      <= 0;
         end else if (hb_start[i]) begin
            age[i] <= 1;
            if (!sticky[i]) done_lvl[i] <= 1'b0;
         end else if (age[i] != 0) begin
            if (sticky[i] && age[i] == 1) done_lvl[i] <= 1'b0;
            if (lat[i] >= 2 && age[i] == lat[i] - 1) begin
               done_lvl[i] <= 1'b1;
               res_out[i]  <= res_val[i];
               age[i]      <= 0;
            end else if (age[i] < 200) begin
               age[i] <= age[i] + 1;
            end else begin
               age[i] <= 0;
            end
         end
      end
   end

   assign hb_done = done_lvl;
   always_comb begin
      for (int i = 0; i < 4; i++) hb_result[i*32 +: 32] = res_out[i];
   end

   typedef struct {
      int          cyc;
      logic [3:0]  ch;
      logic [31:0] res;
      logic        to;
   } ev_t;

   ev_t        evq[$];
   int         st_cyc[$];
   logic [3:0] st_val[$];

   always @(negedge clk) begin
      if (evt_valid) evq.push_back('{cyc, evt_ch, evt_result, evt_timeout});
      if (hb_start != 4'd0) begin
         st_cyc.push_back(cyc);
         st_val.push_back(hb_start);
      end
   end

   task automatic set_units(input int l);
      for (int i = 0; i < 4; i++) begin
         lat[i]      = l;
         sticky[i]   = 1'b0;
         res_val[i]  = 32'hA000_0000 + 32'(i);
         init_res[i] = 32'd0;
      end
      init_done = 4'd0;
   endtask

   task automatic do_reset();
      enable = 1'b0;
      rst_n  = 1'b0;
      repeat (3) @(negedge clk);
      evq.delete();
      st_cyc.delete();
      st_val.delete();
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic wait_cyc(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   // Starts enable at a negedge and returns the cycle index it first applies to.
   task automatic go(output int e);
      @(negedge clk);
      enable = 1'b1;
      e = cyc;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      enable = 1'b0;
      @(negedge clk);
      checks++;
      if (hb_start !== 4'd0 || evt_valid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_ctl got start=%b evt=%b busy=%b exp 0000 0 0", hb_start, evt_valid, busy);
      end
      checks++;
      if (overrun !== 1'b0 || timeout_cnt !== 16'd0) begin
         errors++;
         $display("FAIL reset_status got overrun=%b tcnt=%0d exp 0 0", overrun, timeout_cnt);
      end
      checks++;
      if (evt_ch !== 4'd0 || evt_result !== 32'd0 || evt_timeout !== 1'b0) begin
         errors++;
         $display("FAIL reset_evt got ch=%0d res=%h to=%b exp 0 0 0", evt_ch, evt_result, evt_timeout);
      end
   endtask

   task automatic test_basic();
      int e;
      int ecyc[6];
      logic [3:0] ech[6];
      int scyc[6];
      logic [3:0] sval[6];
      set_units(3);
      period = 16'd20;
      ch_mask = 4'b1011;
      do_reset();
      go(e);
      ecyc = '{e+25, e+30, e+35, e+45, e+50, e+55};
      ech  = '{4'd0, 4'd1, 4'd3, 4'd0, 4'd1, 4'd3};
      scyc = '{e+21, e+26, e+31, e+41, e+46, e+51};
      sval = '{4'b0001, 4'b0010, 4'b1000, 4'b0001, 4'b0010, 4'b1000};
      wait_cyc(e + 28);
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL basic_busy_mid got %b exp 1", busy);
      end
      wait_cyc(e + 38);
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL basic_busy_between got %b exp 0", busy);
      end
      wait_cyc(e + 58);
      enable = 1'b0;
      for (int i = 0; i < 6; i++) begin
         checks++;
         if (i >= evq.size()) begin
            errors++;
            $display("FAIL basic_evt%0d got none exp cyc=%0d ch=%0d", i, ecyc[i], ech[i]);
         end else if (evq[i].cyc !== ecyc[i] || evq[i].ch !== ech[i] ||
                      evq[i].res !== (32'hA000_0000 + 32'(ech[i])) || evq[i].to !== 1'b0) begin
            errors++;
            $display("FAIL basic_evt%0d got cyc=%0d ch=%0d res=%h to=%b exp cyc=%0d ch=%0d res=%h to=0",
                     i, evq[i].cyc, evq[i].ch, evq[i].res, evq[i].to,
                     ecyc[i], ech[i], 32'hA000_0000 + 32'(ech[i]));
         end
      end
      for (int i = 0; i < 6; i++) begin
         checks++;
         if (i >= st_cyc.size()) begin
            errors++;
            $display("FAIL basic_start%0d got none exp cyc=%0d val=%b", i, scyc[i], sval[i]);
         end else if (st_cyc[i] !== scyc[i] || st_val[i] !== sval[i]) begin
            errors++;
            $display("FAIL basic_start%0d got cyc=%0d val=%b exp cyc=%0d val=%b",
                     i, st_cyc[i], st_val[i], scyc[i], sval[i]);
         end
      end
      checks++;
      if (evq.size() !== 6 || st_cyc.size() !== 6 || overrun !== 1'b0) begin
         errors++;
         $display("FAIL basic_totals got evts=%0d starts=%0d overrun=%b exp 6 6 0",
                  evq.size(), st_cyc.size(), overrun);
      end
   endtask

   task automatic test_timeout();
      int e;
      int ecyc[3];
      logic [3:0] ech[3];
      logic [31:0] eres[3];
      logic eto[3];
      set_units(3);
      lat[1] = 0;
      period = 16'd60;
      ch_mask = 4'b1011;
      do_reset();
      go(e);
      ecyc = '{e+65, e+82, e+87};
      ech  = '{4'd0, 4'd1, 4'd3};
      eres = '{32'hA000_0000, 32'd0, 32'hA000_0003};
      eto  = '{1'b0, 1'b1, 1'b0};
      wait_cyc(e + 90);
      enable = 1'b0;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (i >= evq.size()) begin
            errors++;
            $display("FAIL timeout_evt%0d got none exp cyc=%0d ch=%0d", i, ecyc[i], ech[i]);
         end else if (evq[i].cyc !== ecyc[i] || evq[i].ch !== ech[i] ||
                      evq[i].res !== eres[i] || evq[i].to !== eto[i]) begin
            errors++;
            $display("FAIL timeout_evt%0d got cyc=%0d ch=%0d res=%h to=%b exp cyc=%0d ch=%0d res=%h to=%b",
                     i, evq[i].cyc, evq[i].ch, evq[i].res, evq[i].to, ecyc[i], ech[i], eres[i], eto[i]);
         end
      end
      checks++;
      if (timeout_cnt !== 16'd1 || overrun !== 1'b0) begin
         errors++;
         $display("FAIL timeout_cnt got tcnt=%0d overrun=%b exp 1 0", timeout_cnt, overrun);
      end
   endtask

   task automatic test_overrun();
      int e;
      int scyc[6];
      logic [3:0] sval[6];
      set_units(3);
      period = 16'd4;
      ch_mask = 4'b1111;
      do_reset();
      go(e);
      scyc = '{e+5, e+10, e+15, e+20, e+29, e+34};
      sval = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
      wait_cyc(e + 7);
      checks++;
      if (overrun !== 1'b0) begin
         errors++;
         $display("FAIL overrun_early got %b exp 0", overrun);
      end
      wait_cyc(e + 9);
      checks++;
      if (overrun !== 1'b1) begin
         errors++;
         $display("FAIL overrun_set got %b exp 1", overrun);
      end
      wait_cyc(e + 40);
      checks++;
      if (overrun !== 1'b1) begin
         errors++;
         $display("FAIL overrun_sticky got %b exp 1", overrun);
      end
      enable = 1'b0;
      for (int i = 0; i < 6; i++) begin
         checks++;
         if (i >= st_cyc.size()) begin
            errors++;
            $display("FAIL overrun_start%0d got none exp cyc=%0d val=%b", i, scyc[i], sval[i]);
         end else if (st_cyc[i] !== scyc[i] || st_val[i] !== sval[i]) begin
            errors++;
            $display("FAIL overrun_start%0d got cyc=%0d val=%b exp cyc=%0d val=%b",
                     i, st_cyc[i], st_val[i], scyc[i], sval[i]);
         end
      end
   endtask

   task automatic test_stale_done();
      int e;
      set_units(3);
      lat[2]      = 4;
      sticky[2]   = 1'b1;
      res_val[2]  = 32'h5A5A_0002;
      init_done   = 4'b0100;
      init_res[2] = 32'hDEAD_0000;
      period = 16'd10;
      ch_mask = 4'b0100;
      do_reset();
      go(e);
      wait_cyc(e + 19);
      enable = 1'b0;
      checks++;
      if (evq.size() < 1) begin
         errors++;
         $display("FAIL stale_evt got none exp cyc=%0d res=5a5a0002", e + 16);
      end else if (evq[0].cyc !== e + 16 || evq[0].ch !== 4'd2 ||
                   evq[0].res !== 32'h5A5A_0002 || evq[0].to !== 1'b0) begin
         errors++;
         $display("FAIL stale_evt got cyc=%0d ch=%0d res=%h to=%b exp cyc=%0d ch=2 res=5a5a0002 to=0",
                  evq[0].cyc, evq[0].ch, evq[0].res, evq[0].to, e + 16);
      end
      checks++;
      if (evq.size() !== 1) begin
         errors++;
         $display("FAIL stale_count got %0d exp 1", evq.size());
      end
   endtask

   task automatic test_enable_drop();
      int e;
      set_units(3);
      period = 16'd20;
      ch_mask = 4'b1011;
      do_reset();
      go(e);
      wait_cyc(e + 27);
      enable = 1'b0;
      wait_cyc(e + 28);
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL drop_busy_mid got %b exp 1", busy);
      end
      wait_cyc(e + 45);
      checks++;
      if (evq.size() !== 2 || st_cyc.size() !== 2 || busy !== 1'b0) begin
         errors++;
         $display("FAIL drop_totals got evts=%0d starts=%0d busy=%b exp 2 2 0",
                  evq.size(), st_cyc.size(), busy);
      end
      checks++;
      if (evq.size() < 2) begin
         errors++;
         $display("FAIL drop_ch1_evt got none exp cyc=%0d ch=1", e + 30);
      end else if (evq[1].cyc !== e + 30 || evq[1].ch !== 4'd1 || evq[1].res !== 32'hA000_0001) begin
         errors++;
         $display("FAIL drop_ch1_evt got cyc=%0d ch=%0d res=%h exp cyc=%0d ch=1 res=a0000001",
                  evq[1].cyc, evq[1].ch, evq[1].res, e + 30);
      end
   endtask

   task automatic test_reset_mid();
      int e;
      int r;
      set_units(3);
      lat[1] = 0;
      period = 16'd4;
      ch_mask = 4'b1111;
      do_reset();
      go(e);
      wait_cyc(e + 27);
      checks++;
      if (hb_start !== 4'b0100 || busy !== 1'b1 || overrun !== 1'b1 || timeout_cnt !== 16'd1) begin
         errors++;
         $display("FAIL rmid_pre got start=%b busy=%b overrun=%b tcnt=%0d exp 0100 1 1 1",
                  hb_start, busy, overrun, timeout_cnt);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (hb_start !== 4'd0 || evt_valid !== 1'b0 || busy !== 1'b0 ||
          overrun !== 1'b0 || timeout_cnt !== 16'd0) begin
         errors++;
         $display("FAIL rmid_async got start=%b evt=%b busy=%b overrun=%b tcnt=%0d exp 0000 0 0 0 0",
                  hb_start, evt_valid, busy, overrun, timeout_cnt);
      end
      repeat (2) @(negedge clk);
      evq.delete();
      st_cyc.delete();
      st_val.delete();
      rst_n = 1'b1;
      r = cyc;
      wait_cyc(r + 7);
      checks++;
      if (st_cyc.size() < 1) begin
         errors++;
         $display("FAIL rmid_first_start got none exp cyc=%0d val=0001", r + 5);
      end else if (st_cyc[0] !== r + 5 || st_val[0] !== 4'b0001) begin
         errors++;
         $display("FAIL rmid_first_start got cyc=%0d val=%b exp cyc=%0d val=0001",
                  st_cyc[0], st_val[0], r + 5);
      end
      checks++;
      if (evq.size() !== 0) begin
         errors++;
         $display("FAIL rmid_no_evt got %0d events exp 0", evq.size());
      end
      enable = 1'b0;
   endtask

   initial begin
      set_units(3);
      test_reset();
      test_basic();
      test_timeout();
      test_overrun();
      test_stale_done();
      test_enable_drop();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
